load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage for the 32-bit CPU. Takes the ALU-computed address and store data, runs a single request/acknowledge transaction on the data-memory bus, and returns aligned, sign- or zero-extended load data as `read_data` for the writeback select. It also drives a `busy` stall to the controller while a transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request from the controller; sampled only in IDLE
- `mem_read`  in  1  load request
- `mem_write`  in  1  store request; takes precedence if both are high
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `is_unsigned`  in  1  zero-extend loads when 1, sign-extend when 0
- `addr`  in  ADDR_W  byte address (the ALU result)
- `write_data`  in  32  store data, right-justified
- `read_data`  out  32  extended load result; holds until the next load completes
- `busy`  out  1  stall to the controller
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  one-cycle pulse, coincident with `done`, for a rejected access
- `bus_req`  out  1  bus request
- `bus_we`  out  1  write enable
- `bus_addr`  out  ADDR_W  word address (`addr` with the low 2 bits cleared)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_ack`  in  1  memory acknowledge
- `bus_rdata`  in  32  read word; valid when `bus_ack` is high

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE, accepted request:** `start` high with `mem_read` or `mem_write` high.
  - Address aligned: latch the request and go to BUS.
  - Misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to RESP with the error flag set. No bus access occurs.
- **IDLE, ignored:** `start` with neither `mem_read` nor `mem_write` high does nothing. `start` outside IDLE is also ignored.
- **BUS:**
  - `bus_req`=1. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` stay stable until the ack.
  - On `bus_ack`, for a read: extract the lane selected by `addr[1:0]`/`size`, extend it, and register the result into `read_data`. Then go to RESP.
- **RESP:** `done`=1, `misaligned`=error flag, then return to IDLE.
- **`busy`:** high in BUS and RESP, and combinationally high in IDLE while an accepted `start` is present.
- **Byte enables:** byte → `4'b0001<<addr[1:0]`; half → `4'b0011<<addr[1:0]`; word → `4'b1111`.
- **Store data:** byte → `{4{wd[7:0]}}`; half → `{2{wd[15:0]}}`; word → `wd`.
- Stores and misaligned accesses leave `read_data` unchanged.
- **Reset** (also mid-transaction): state IDLE; `read_data`=0; `busy`, `done`, `misaligned`, `bus_req`, `bus_we`=0; `bus_addr`, `bus_be`, `bus_wdata`=0.
  - A `bus_ack` arriving after reset is ignored.
  - A `start` in the same cycle as `rst` is dropped.

## Timing
- `start` sampled at edge 0 → `bus_req` high from cycle 1.
- `bus_ack` sampled at edge k (k≥1) → `bus_req` low and `done` high in cycle k+1. `read_data` is valid from cycle k+1.
- Minimum transaction length is 3 cycles: start, one BUS cycle with an immediate ack, RESP.
- Misaligned access: `done` and `misaligned` in cycle 1.
- A new `start` is accepted no earlier than the cycle after RESP.
- `bus_ack` while not in BUS is ignored.

## Structure
- Package `lsu_pkg` holds:
  - `size_t` enum: BYTE, HALF, WORD
  - `lsu_state_t` enum: IDLE, BUS, RESP
  - constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
- Sub-module `lsu_align` is purely combinational. It generates byte enables and the replicated store data, and performs load lane extraction plus extension. The top level holds the FSM and registers.

## Test plan
- Word load, `addr`=0x100, ack 2 cycles after `bus_req` rises, `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111; `read_data`=0xDEADBEEF, `done` 1 cycle after ack.
- Signed byte load, `addr`=0x103, `bus_rdata`=0x80FF1234 → `bus_be`=1000, `read_data`=0xFFFFFF80. The same access with `is_unsigned`=1 → 0x00000080.
- Half store, `addr`=0x202, `write_data`=0x0000ABCD → `bus_we`=1, `bus_addr`=0x200, `bus_be`=1100, `bus_wdata`=0xABCDABCD; `read_data` unchanged.
- Misaligned word load, `addr`=0x301 → `done`=`misaligned`=1 in cycle 1; `bus_req` never asserted.
- `rst` asserted while in BUS, with a late `bus_ack` afterwards → `bus_req` is 0 the next cycle; no `done`; `read_data`=0.
- `start` pulsed while in BUS, with `mem_read` and `mem_write` both high on a fresh start → first pulse ignored; the fresh start performs a write.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, FSM states and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic size_t decode_size(
    input logic [1:0] s
  );
    size_t r;
    case (s)
      SZ_BYTE: r = BYTE;
      SZ_HALF: r = HALF;
      default: r = WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(
    input size_t      sz,
    input logic [1:0] lo
  );
    logic r;
    case (sz)
      HALF:    r = lo[0];
      WORD:    r = |lo;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, store replication,
// load lane extraction and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        mis_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    mis_o   = is_misaligned(size_i, lo_i);
    case (size_i)
      BYTE: begin
        be_o    = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & shifted[7]}},
                   shifted[7:0]};
      end
      HALF: begin
        be_o    = 4'b0011 << lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & shifted[15]}},
                   shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack bus transaction
// per accepted request, with aligned load return.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_t state_q, state_d;

  logic              we_q;
  size_t             size_q;
  logic [1:0]        lo_q;
  logic              uns_q;
  logic              err_q;
  logic [DATA_W-1:0] read_data_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic              idle;
  logic              accept;
  size_t             al_size;
  logic [1:0]        al_lo;
  logic              al_uns;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_mis;

  assign idle   = (state_q == IDLE);
  assign accept = idle & start & ~rst
                & (mem_read | mem_write);

  // One aligner serves the request in IDLE and the
  // latched load descriptor while in BUS.
  assign al_size = idle ? decode_size(size) : size_q;
  assign al_lo   = idle ? addr[1:0] : lo_q;
  assign al_uns  = idle ? is_unsigned : uns_q;

  lsu_align u_align (
    .size_i  (al_size),
    .lo_i    (al_lo),
    .uns_i   (al_uns),
    .wdata_i (write_data),
    .rdata_i (bus_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata),
    .mis_o   (al_mis)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = al_mis ? RESP : BUS;
      end
      BUS: begin
        if (bus_ack)
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= WORD;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= mem_write;
        size_q <= al_size;
        lo_q   <= addr[1:0];
        uns_q  <= is_unsigned;
        err_q  <= al_mis;
        if (!al_mis) begin
          bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
          bus_be_q    <= al_be;
          bus_wdata_q <= al_wdata;
        end
      end
      if ((state_q == BUS) && bus_ack && !we_q)
        read_data_q <= al_rdata;
    end
  end

  assign read_data  = read_data_q;
  assign busy       = ~idle | accept;
  assign done       = (state_q == RESP);
  assign misaligned = done & err_q;
  assign bus_req    = (state_q == BUS);
  assign bus_we     = bus_req & we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus
// random transactions against a behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rd_model;

  load_store_unit #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .is_unsigned (is_unsigned),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .busy        (busy),
    .done        (done),
    .misaligned  (misaligned),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(
    input bit          we,
    input bit          rd,
    input logic [1:0]  sz,
    input bit          uns,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rdat,
    input int          dly,
    input bit          poke
  );
    int          n;
    int          lo;
    bit          mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] sh;
    longint      v;
    longint      span;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo   = int'(a[1:0]);
    mis  = (lo % n) != 0;
    ebe  = '0;
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + n) ebe[i] = 1'b1;
    for (int i = 0; i < 4; i++)
      ewd[8*i +: 8] = wd[8*(i % n) +: 8];
    sh   = rdat >> (8 * lo);
    span = longint'(1) << (8 * n);
    v    = longint'(sh) % span;
    if (!uns && v >= span / 2) v = v - span;

    start       = 1'b1;
    mem_read    = rd;
    mem_write   = we;
    size        = sz;
    is_unsigned = uns;
    addr        = a;
    write_data  = wd;
    #1;
    check("busy_start", busy, 1);
    step();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = $urandom;
    if (mis) begin
      check("mis_done", done, 1);
      check("mis_flag", misaligned, 1);
      check("mis_req", bus_req, 0);
      step();
      check("mis_done_end", done, 0);
      check("mis_rdata", read_data, rd_model);
      return;
    end
    check("req", bus_req, 1);
    check("we", bus_we, we);
    check("baddr", bus_addr, a & ~32'd3);
    check("be", bus_be, ebe);
    check("wdata", bus_wdata, ewd);
    for (int c = 0; c < dly; c++) begin
      if (poke && c == 0) begin
        start     = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        size      = 2'd2;
        addr      = 32'h0000_0F00;
      end
      step();
      start     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      check("wait_req", bus_req, 1);
      check("wait_we", bus_we, we);
      check("wait_addr", bus_addr, a & ~32'd3);
      check("wait_done", done, 0);
    end
    bus_ack   = 1'b1;
    bus_rdata = rdat;
    step();
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (!we) rd_model = v[31:0];
    check("done", done, 1);
    check("misf", misaligned, 0);
    check("req_drop", bus_req, 0);
    check("busy_resp", busy, 1);
    check("rdata", read_data, rd_model);
    step();
    check("done_end", done, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    size        = 2'd0;
    is_unsigned = 1'b0;
    addr        = '0;
    write_data  = '0;
    bus_ack     = 1'b0;
    bus_rdata   = '0;
    rd_model    = '0;
    step();
    step();
    check("rst_rdata", read_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", bus_req, 0);
    check("rst_be", bus_be, 0);
    rst = 1'b0;
    step();

    txn(0, 1, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0);
    check("t1_word", read_data, 32'hDEADBEEF);
    txn(0, 1, 2'd0, 0, 32'h103, 0, 32'h80FF1234, 0, 0);
    check("t2_sbyte", read_data, 32'hFFFFFF80);
    txn(0, 1, 2'd0, 1, 32'h103, 0, 32'h80FF1234, 1, 0);
    check("t2_ubyte", read_data, 32'h00000080);
    txn(1, 0, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 1, 0);
    check("t3_hold", read_data, 32'h00000080);
    txn(0, 1, 2'd2, 0, 32'h301, 0, 0, 0, 0);

    start    = 1'b1;
    mem_read = 1'b1;
    size     = 2'd2;
    addr     = 32'h400;
    step();
    start    = 1'b0;
    mem_read = 1'b0;
    check("r_req", bus_req, 1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    rd_model = '0;
    check("r_req0", bus_req, 0);
    check("r_busy", busy, 0);
    check("r_rdata", read_data, 0);
    check("r_baddr", bus_addr, 0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0;
    check("r_late_done", done, 0);
    check("r_late_rdata", read_data, 0);

    rst      = 1'b1;
    start    = 1'b1;
    mem_read = 1'b1;
    #1;
    check("rs_busy", busy, 0);
    step();
    rst      = 1'b0;
    start    = 1'b0;
    mem_read = 1'b0;
    check("rs_req", bus_req, 0);
    step();
    check("rs_done", done, 0);

    start = 1'b1;
    #1;
    check("ign_busy", busy, 0);
    step();
    start = 1'b0;
    check("ign_req", bus_req, 0);

    txn(0, 1, 2'd2, 0, 32'h500, 0, 32'hCAFEF00D, 2, 1);
    txn(1, 1, 2'd2, 0, 32'h600, 32'h11223344, 32'h0, 0, 0);
    check("both_keep", read_data, 32'hCAFEF00D);

    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 2);
      txn(op != 0, op != 1,
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom,
          $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
